// File: rtl/seq_mem_pkg.sv
// Shared types and helpers for the sequence-controller memory responder.
package seq_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StRdHold = 2'd2,
        StWrHold = 2'd3
    } state_t;

    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefDepth   = 32;
    localparam int unsigned DefReadLat = 1;

    // Widest data word the merge helper supports; callers cast down to their width.
    localparam int unsigned MaxDataW = 64;

    // Bit-masked merge: a 1 in mask takes the new bit, a 0 keeps the old bit.
    function automatic logic [MaxDataW-1:0] masked_merge(
        input logic [MaxDataW-1:0] old_word,
        input logic [MaxDataW-1:0] new_word,
        input logic [MaxDataW-1:0] mask
    );
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/seq_mem_array.sv
// Word storage with a synchronous bit-masked write port and a combinational read port.
module seq_mem_array
    import seq_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              waddr_ok,
    output logic              raddr_ok
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IdxW-1:0]   widx;
    logic [IdxW-1:0]   ridx;
    logic [DATA_W-1:0] merged;

    // Range checks and index/merge computation
    always_comb begin
        waddr_ok = 32'(waddr) < DEPTH;
        raddr_ok = 32'(raddr) < DEPTH;
        widx     = waddr[IdxW-1:0];
        ridx     = raddr[IdxW-1:0];
        merged   = DATA_W'(masked_merge(MaxDataW'(mem[widx]), MaxDataW'(wdata),
                                        MaxDataW'(wmask)));
    end

    // Masked write; out-of-range addresses never touch storage
    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[widx] <= merged;
        end
    end

    // Out-of-range reads return zero rather than an aliased word
    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[ridx];
        end
    end

endmodule

// File: rtl/seq_mem_responder.sv
// Memory-side responder: answers mem_rd/mem_rw level strobes with wait-stated reads
// and single-shot masked writes.
module seq_mem_responder
    import seq_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned READ_LAT = DefReadLat
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] wr_mask,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              wr_done,
    output logic              err
);

    localparam int unsigned   CntW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              wr_done_q, wr_done_d;
    logic              err_q, err_d;
    logic              we;
    logic              waddr_ok;
    logic              raddr_ok;
    logic [DATA_W-1:0] rdata;

    seq_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk      (clk),
        .we       (we),
        .waddr    (addr),
        .wdata    (data_in),
        .wmask    (wr_mask),
        .raddr    (raddr_q),
        .rdata    (rdata),
        .waddr_ok (waddr_ok),
        .raddr_ok (raddr_ok)
    );

    // Next-state, write strobe and output-register updates
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        wr_done_d = 1'b0;
        err_d     = 1'b0;
        we        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_rd && mem_rw) begin
                    err_d = 1'b1;
                end else if (mem_rd) begin
                    raddr_d = addr;
                    cnt_d   = CntInit;
                    state_d = StRdWait;
                end else if (mem_rw) begin
                    // Gated by reset so a write is never half-committed
                    we        = !reset;
                    wr_done_d = waddr_ok;
                    err_d     = !waddr_ok;
                    state_d   = StWrHold;
                end
            end
            StRdWait: begin
                if (!mem_rd) begin
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    dout_d   = rdata;
                    err_d    = !raddr_ok;
                    dvalid_d = 1'b1;
                    state_d  = StRdHold;
                end
            end
            StRdHold: begin
                if (!mem_rd) begin
                    dvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            StWrHold: begin
                if (!mem_rw) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            raddr_q   <= '0;
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            raddr_q   <= raddr_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            wr_done_q <= wr_done_d;
            err_q     <= err_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign wr_done    = wr_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seq_mem_responder.sv
// Self-checking bench: instance 0 uses defaults, instance 1 uses DEPTH=20, READ_LAT=3.
module tb_seq_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd [2];
    logic       rw [2];
    logic [4:0] ad [2];
    logic [7:0] din [2];
    logic [7:0] msk [2];
    logic [7:0] dout [2];
    logic       dv [2];
    logic       wd [2];
    logic       er [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_mem_responder #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(32), .READ_LAT(1)
    ) u_a (
        .clk(clk), .reset(reset), .mem_rd(rd[0]), .mem_rw(rw[0]), .addr(ad[0]),
        .data_in(din[0]), .wr_mask(msk[0]), .data_out(dout[0]), .data_valid(dv[0]),
        .wr_done(wd[0]), .err(er[0])
    );

    seq_mem_responder #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(20), .READ_LAT(3)
    ) u_b (
        .clk(clk), .reset(reset), .mem_rd(rd[1]), .mem_rw(rw[1]), .addr(ad[1]),
        .data_in(din[1]), .wr_mask(msk[1]), .data_out(dout[1]), .data_valid(dv[1]),
        .wr_done(wd[1]), .err(er[1])
    );

    // Transaction-level model: phase 0 free, 1 reading, 2 write held.
    typedef struct packed {
        logic [31:0][7:0] mem;
        logic [1:0]       phase;
        logic [7:0]       age;
        logic [4:0]       ra;
        logic [7:0]       dout;
        logic             dv;
        logic             wd;
        logic             er;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t clr(mdl_t s);
        mdl_t n = s;
        n.phase = 2'd0; n.age = 8'd0; n.dout = 8'd0; n.dv = 1'b0; n.wd = 1'b0; n.er = 1'b0;
        return n;
    endfunction

    function automatic mdl_t step(mdl_t s, logic r, logic w, logic [4:0] a, logic [7:0] d,
                                  logic [7:0] k, int dep, int lat);
        mdl_t n = s;
        n.wd = 1'b0;
        n.er = 1'b0;
        if (s.phase == 2'd0) begin
            if (r && w) begin
                n.er = 1'b1;
            end else if (r) begin
                n.phase = 2'd1; n.age = 8'd0; n.ra = a;
            end else if (w) begin
                if (int'(a) < dep) begin
                    n.mem[a] = (s.mem[a] & ~k) | (d & k);
                    n.wd = 1'b1;
                end else begin
                    n.er = 1'b1;
                end
                n.phase = 2'd2;
            end
        end else if (s.phase == 2'd1) begin
            if (!r) begin
                n.phase = 2'd0; n.dv = 1'b0;
            end else if (!s.dv) begin
                n.age = s.age + 8'd1;
                if (int'(n.age) == lat) begin
                    n.dv = 1'b1;
                    if (int'(s.ra) < dep) begin
                        n.dout = s.mem[s.ra];
                    end else begin
                        n.dout = 8'd0; n.er = 1'b1;
                    end
                end
            end
        end else begin
            if (!w) n.phase = 2'd0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) m[i] <= clr(m[i]);
            else m[i] <= step(m[i], rd[i], rw[i], ad[i], din[i], msk[i],
                              (i == 0) ? 32 : 20, (i == 0) ? 1 : 3);
        end
    end

    task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mdl_dout%0d", i), dout[i], m[i].dout);
            chk($sformatf("mdl_dv%0d", i), 8'(dv[i]), 8'(m[i].dv));
            chk($sformatf("mdl_wd%0d", i), 8'(wd[i]), 8'(m[i].wd));
            chk($sformatf("mdl_er%0d", i), 8'(er[i]), 8'(m[i].er));
        end
    end

    // Drive one cycle of inputs just after a negedge, return at the next negedge
    task automatic cyc(int i, logic r, logic w, logic [4:0] a, logic [7:0] d, logic [7:0] k);
        #1;
        rd[i] = r; rw[i] = w; ad[i] = a; din[i] = d; msk[i] = k;
        @(negedge clk);
    endtask

    task automatic wr(int i, logic [4:0] a, logic [7:0] d, logic [7:0] k);
        cyc(i, 1'b0, 1'b1, a, d, k);
        cyc(i, 1'b0, 1'b0, a, d, k);
    endtask

    task automatic rd_chk(int i, logic [4:0] a, logic [7:0] exp, string nm);
        cyc(i, 1'b1, 1'b0, a, 8'h00, 8'h00);
        for (int c = 0; c < ((i == 0) ? 1 : 3); c++) begin
            chk({nm, "_early_dv"}, 8'(dv[i]), 8'd0);
            cyc(i, 1'b1, 1'b0, a, 8'h00, 8'h00);
        end
        chk({nm, "_dv"}, 8'(dv[i]), 8'd1);
        chk({nm, "_data"}, dout[i], exp);
        cyc(i, 1'b0, 1'b0, a, 8'h00, 8'h00);
    endtask

    task automatic pulse_reset(string nm);
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_dout%0d", nm, i), dout[i], 8'd0);
            chk($sformatf("%s_dv%0d", nm, i), 8'(dv[i]), 8'd0);
            chk($sformatf("%s_wd%0d", nm, i), 8'(wd[i]), 8'd0);
            chk($sformatf("%s_er%0d", nm, i), 8'(er[i]), 8'd0);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; rw[i] = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; rw[i] = 1'b0; ad[i] = 5'd0; din[i] = 8'd0; msk[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        chk("rst_dout", dout[0], 8'd0);
        chk("rst_dv", 8'(dv[0]), 8'd0);
        chk("rst_wd", 8'(wd[0]), 8'd0);
        chk("rst_er", 8'(er[0]), 8'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Full write held two cycles: exactly one wr_done pulse
        cyc(0, 1'b0, 1'b1, 5'd3, 8'hA5, 8'hFF);
        chk("w1_wd", 8'(wd[0]), 8'd1);
        cyc(0, 1'b0, 1'b1, 5'd3, 8'hA5, 8'hFF);
        chk("w1_wd_once", 8'(wd[0]), 8'd0);
        cyc(0, 1'b0, 1'b0, 5'd3, 8'hA5, 8'hFF);
        // Read with address changing during hold
        cyc(0, 1'b1, 1'b0, 5'd3, 8'h00, 8'h00);
        chk("r1_dv_lat", 8'(dv[0]), 8'd0);
        cyc(0, 1'b1, 1'b0, 5'd7, 8'h00, 8'h00);
        chk("r1_dv", 8'(dv[0]), 8'd1);
        chk("r1_data", dout[0], 8'hA5);
        cyc(0, 1'b1, 1'b0, 5'd9, 8'h00, 8'h00);
        chk("r1_hold", dout[0], 8'hA5);
        cyc(0, 1'b0, 1'b0, 5'd9, 8'h00, 8'h00);
        chk("r1_drop_dv", 8'(dv[0]), 8'd0);
        chk("r1_drop_data", dout[0], 8'hA5);

        // Masked write: (A5 & ~3C) | (0F & 3C) = 8D
        wr(0, 5'd3, 8'h0F, 8'h3C);
        rd_chk(0, 5'd3, 8'h8D, "mask");

        // READ_LAT=3 instance
        wr(1, 5'd2, 8'h5A, 8'hFF);
        wr(1, 5'd4, 8'h33, 8'hFF);
        wr(1, 5'd5, 8'h11, 8'hFF);
        rd_chk(1, 5'd2, 8'h5A, "lat3");
        // Abort: mem_rd dropped at k+2
        cyc(1, 1'b1, 1'b0, 5'd4, 8'h00, 8'h00);
        cyc(1, 1'b1, 1'b0, 5'd4, 8'h00, 8'h00);
        cyc(1, 1'b0, 1'b0, 5'd4, 8'h00, 8'h00);
        chk("abort_dv", 8'(dv[1]), 8'd0);
        chk("abort_data", dout[1], 8'h5A);
        cyc(1, 1'b0, 1'b0, 5'd4, 8'h00, 8'h00);
        chk("abort_dv2", 8'(dv[1]), 8'd0);

        // Out-of-range write and read with DEPTH=20
        cyc(1, 1'b0, 1'b1, 5'd25, 8'hEE, 8'hFF);
        chk("oob_w_er", 8'(er[1]), 8'd1);
        chk("oob_w_wd", 8'(wd[1]), 8'd0);
        cyc(1, 1'b0, 1'b0, 5'd25, 8'hEE, 8'hFF);
        chk("oob_w_er_pulse", 8'(er[1]), 8'd0);
        cyc(1, 1'b1, 1'b0, 5'd25, 8'h00, 8'h00);
        cyc(1, 1'b1, 1'b0, 5'd25, 8'h00, 8'h00);
        cyc(1, 1'b1, 1'b0, 5'd25, 8'h00, 8'h00);
        cyc(1, 1'b1, 1'b0, 5'd25, 8'h00, 8'h00);
        chk("oob_r_dv", 8'(dv[1]), 8'd1);
        chk("oob_r_data", dout[1], 8'h00);
        chk("oob_r_er", 8'(er[1]), 8'd1);
        cyc(1, 1'b0, 1'b0, 5'd25, 8'h00, 8'h00);
        rd_chk(1, 5'd5, 8'h11, "oob_noalias");

        // Both strobes high in IDLE
        wr(0, 5'd5, 8'h66, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 1'b1, 1'b1, 5'd5, 8'hAA, 8'hFF);
            chk("both_er", 8'(er[0]), 8'd1);
            chk("both_wd", 8'(wd[0]), 8'd0);
            chk("both_dv", 8'(dv[0]), 8'd0);
        end
        cyc(0, 1'b0, 1'b0, 5'd5, 8'h00, 8'h00);
        chk("both_er_end", 8'(er[0]), 8'd0);
        rd_chk(0, 5'd5, 8'h66, "both_nowrite");

        // Reset during RD_WAIT (instance 1) and during WR_HOLD (instance 0)
        cyc(1, 1'b1, 1'b0, 5'd2, 8'h00, 8'h00);
        cyc(1, 1'b1, 1'b0, 5'd2, 8'h00, 8'h00);
        pulse_reset("rst_rdwait");
        cyc(0, 1'b0, 1'b1, 5'd6, 8'h77, 8'hFF);
        chk("rst_w_wd", 8'(wd[0]), 8'd1);
        pulse_reset("rst_wrhold");
        rd_chk(0, 5'd6, 8'h77, "post_rst_w");
        rd_chk(0, 5'd3, 8'h8D, "post_rst_keep");
        rd_chk(1, 5'd2, 8'h5A, "post_rst_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
